// File: rtl/axi_isolate_pkg.sv
// Shared types and defaults for the AXI isolation controller.
// The state enum is the FSM encoding; the localparams are the default sizing.
package axi_isolate_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2,
    RELEASE  = 2'd3
  } iso_state_e;

  localparam int unsigned DEFAULT_MAX_OUTSTANDING = 16;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES  = 1024;

endpackage

// File: rtl/axi_iso_outstanding_cnt.sv
// Saturating inc/dec counter of in-flight transactions with full/empty flags.
// One instance tracks writes (AW vs B), another tracks reads (AR vs R-last).
module axi_iso_outstanding_cnt #(
  parameter int unsigned MAX_COUNT = 16,
  parameter int unsigned WIDTH     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_COUNT);

  assign full  = (count == MAX_VAL);
  assign empty = (count == '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !dec && !full) begin
      count <= count + WIDTH'(1);
    end else if (dec && !inc && !empty) begin
      count <= count - WIDTH'(1);
    end
  end

  // A response with nothing outstanding means the downstream protocol is broken.
  dec_at_zero: assert property (@(posedge clk) disable iff (!rst_n)
    !(dec && !inc && empty && !clr));

endmodule

// File: rtl/axi_isolate_ctrl.sv
// Gates AW/AR, drains outstanding traffic, then isolates the slice wrapper port.
// Optional drain timeout is compiled in with `define AXI_ISOLATE_TIMEOUT_EN.
module axi_isolate_ctrl
  import axi_isolate_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
  parameter int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1),
  parameter int unsigned TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 isolate_req_i,
  output logic                 isolate_ack_o,
  output logic                 isolate_o,
  input  logic                 aw_valid_i,
  input  logic                 aw_ready_i,
  output logic                 aw_valid_o,
  output logic                 aw_ready_o,
  input  logic                 ar_valid_i,
  input  logic                 ar_ready_i,
  output logic                 ar_valid_o,
  output logic                 ar_ready_o,
  input  logic                 b_valid_i,
  input  logic                 b_ready_i,
  input  logic                 r_valid_i,
  input  logic                 r_ready_i,
  input  logic                 r_last_i,
  output logic [CNT_WIDTH-1:0] wr_outstanding_o,
  output logic [CNT_WIDTH-1:0] rd_outstanding_o,
  output logic                 timeout_o
);

  iso_state_e state;
  logic aw_pend, ar_pend;
  logic wr_full, wr_empty, rd_full, rd_empty;
  logic block_aw, block_ar;
  logic aw_hs, ar_hs, b_hs, r_hs;
  logic drained, cnt_clr;

  // A request already presented downstream (pend) is never gated off.
  assign block_aw = ((state != RUN) || wr_full) && !aw_pend;
  assign block_ar = ((state != RUN) || rd_full) && !ar_pend;

  assign aw_valid_o = aw_valid_i && !block_aw;
  assign aw_ready_o = aw_ready_i && !block_aw;
  assign ar_valid_o = ar_valid_i && !block_ar;
  assign ar_ready_o = ar_ready_i && !block_ar;

  assign aw_hs = aw_valid_o && aw_ready_i;
  assign ar_hs = ar_valid_o && ar_ready_i;
  assign b_hs  = b_valid_i && b_ready_i;
  assign r_hs  = r_valid_i && r_ready_i && r_last_i;

  assign drained = wr_empty && rd_empty && !aw_pend && !ar_pend;

  axi_iso_outstanding_cnt #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .WIDTH     (CNT_WIDTH)
  ) u_wr_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (aw_hs),
    .dec   (b_hs),
    .clr   (cnt_clr),
    .count (wr_outstanding_o),
    .full  (wr_full),
    .empty (wr_empty)
  );

  axi_iso_outstanding_cnt #(
    .MAX_COUNT (MAX_OUTSTANDING),
    .WIDTH     (CNT_WIDTH)
  ) u_rd_cnt (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .inc   (ar_hs),
    .dec   (r_hs),
    .clr   (cnt_clr),
    .count (rd_outstanding_o),
    .full  (rd_full),
    .empty (rd_empty)
  );

`ifdef AXI_ISOLATE_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] timer;
  logic             timeout_q;

  // Fires on the last DRAIN cycle of the budget unless draining or aborting wins.
  assign cnt_clr   = (state == DRAIN) && isolate_req_i && !drained && (timer == TMR_W'(1));
  assign timeout_o = timeout_q;

  // Timer is held at the full budget outside DRAIN, so it is loaded on entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer     <= TMR_W'(TIMEOUT_CYCLES);
      timeout_q <= 1'b0;
    end else begin
      if (cnt_clr) timeout_q <= 1'b1;
      if (state != DRAIN) begin
        timer <= TMR_W'(TIMEOUT_CYCLES);
      end else if (timer != '0) begin
        timer <= timer - TMR_W'(1);
      end
    end
  end
`else
  assign cnt_clr   = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_pend <= 1'b0;
      ar_pend <= 1'b0;
    end else if (cnt_clr) begin
      aw_pend <= 1'b0;
      ar_pend <= 1'b0;
    end else begin
      if (aw_valid_o && !aw_ready_i) aw_pend <= 1'b1;
      else if (aw_hs)                aw_pend <= 1'b0;
      if (ar_valid_o && !ar_ready_i) ar_pend <= 1'b1;
      else if (ar_hs)                ar_pend <= 1'b0;
    end
  end

  // Outputs are registered alongside the state so they change on the entry edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= RUN;
      isolate_o     <= 1'b0;
      isolate_ack_o <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (isolate_req_i) state <= DRAIN;
        end
        DRAIN: begin
          if (!isolate_req_i) begin
            state <= RUN;
          end else if (drained || cnt_clr) begin
            state         <= ISOLATED;
            isolate_o     <= 1'b1;
            isolate_ack_o <= 1'b1;
          end
        end
        ISOLATED: begin
          if (!isolate_req_i) begin
            state         <= RELEASE;
            isolate_o     <= 1'b0;
            isolate_ack_o <= 1'b0;
          end
        end
        RELEASE: begin
          state <= isolate_req_i ? DRAIN : RUN;
        end
        default: begin
          state         <= RUN;
          isolate_o     <= 1'b0;
          isolate_ack_o <= 1'b0;
        end
      endcase
    end
  end

  timeout_param_ok: assert property (@(posedge clk_i) TIMEOUT_CYCLES >= 1);

  isolated_is_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    isolate_o |-> (wr_empty && rd_empty));

  aw_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (aw_valid_o && !aw_ready_i && !cnt_clr) |=> (aw_valid_o || !aw_valid_i));

  ar_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ar_valid_o && !ar_ready_i && !cnt_clr) |=> (ar_valid_o || !ar_valid_i));

endmodule

// File: tb/tb_axi_isolate_ctrl.sv
// Self-checking bench for axi_isolate_ctrl: vector table, corner sequences and
// a randomized run against a cycle-level model of the isolation rules.
module tb_axi_isolate_ctrl;

  localparam int MAXO = 16;
`ifdef AXI_ISOLATE_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 1024;
`endif
  localparam int CW = $clog2(MAXO + 1);

  localparam int M_RUN = 0, M_DRAIN = 1, M_ISO = 2, M_REL = 3;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic isolate_req_i, isolate_ack_o, isolate_o;
  logic aw_valid_i, aw_ready_i, aw_valid_o, aw_ready_o;
  logic ar_valid_i, ar_ready_i, ar_valid_o, ar_ready_o;
  logic b_valid_i, b_ready_i, r_valid_i, r_ready_i, r_last_i;
  logic [CW-1:0] wr_outstanding_o, rd_outstanding_o;
  logic timeout_o;

  axi_isolate_ctrl #(
    .MAX_OUTSTANDING (MAXO),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .isolate_req_i    (isolate_req_i),
    .isolate_ack_o    (isolate_ack_o),
    .isolate_o        (isolate_o),
    .aw_valid_i       (aw_valid_i),
    .aw_ready_i       (aw_ready_i),
    .aw_valid_o       (aw_valid_o),
    .aw_ready_o       (aw_ready_o),
    .ar_valid_i       (ar_valid_i),
    .ar_ready_i       (ar_ready_i),
    .ar_valid_o       (ar_valid_o),
    .ar_ready_o       (ar_ready_o),
    .b_valid_i        (b_valid_i),
    .b_ready_i        (b_ready_i),
    .r_valid_i        (r_valid_i),
    .r_ready_i        (r_ready_i),
    .r_last_i         (r_last_i),
    .wr_outstanding_o (wr_outstanding_o),
    .rd_outstanding_o (rd_outstanding_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic req, awv, awr, arv, arr, bv, br, rv, rr, rl);
    isolate_req_i = req;
    aw_valid_i = awv; aw_ready_i = awr;
    ar_valid_i = arv; ar_ready_i = arr;
    b_valid_i = bv;   b_ready_i = br;
    r_valid_i = rv;   r_ready_i = rr; r_last_i = rl;
  endtask

  // Apply inputs, then sample mid-cycle on the falling edge.
  task automatic step(input logic req, awv, awr, arv, arr, bv, br, rv, rr, rl);
    drive(req, awv, awr, arv, arr, bv, br, rv, rr, rl);
    @(negedge clk_i);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  typedef struct {
    logic req, awv, awr, bv, br;
    logic e_awv, e_awr, e_iso, e_ack;
    int   e_wr;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] in, input logic [3:0] ex, input int wr);
    vec_t v;
    {v.req, v.awv, v.awr, v.bv, v.br} = in;
    {v.e_awv, v.e_awr, v.e_iso, v.e_ack} = ex;
    v.e_wr = wr;
    return v;
  endfunction

  vec_t tbl[15];

  // Reference model state.
  int   m_mode, m_wr, m_rd, m_tmr;
  logic m_awp, m_arp, m_iso, m_ack, m_tout;
  logic r_req, awv, awr, arv, arr, bv, br, rv, rr, rl, heavy;
  logic e_awv, e_awr, e_arv, e_arr, gw, gr, drained, fire;

  initial begin : main
    int n;
    // inputs {req,awv,awr,bv,br}, expected {aw_valid_o,aw_ready_o,isolate_o,ack}, wr
    tbl[0]  = mk(5'b10000, 4'b0000, 0);
    tbl[1]  = mk(5'b11100, 4'b0000, 0);
    tbl[2]  = mk(5'b11100, 4'b0011, 0);
    tbl[3]  = mk(5'b01100, 4'b0011, 0);
    tbl[4]  = mk(5'b01100, 4'b0000, 0);
    tbl[5]  = mk(5'b01100, 4'b1100, 0);
    tbl[6]  = mk(5'b01100, 4'b1100, 1);
    tbl[7]  = mk(5'b01100, 4'b1100, 2);
    tbl[8]  = mk(5'b10000, 4'b0000, 3);
    tbl[9]  = mk(5'b11100, 4'b0000, 3);
    tbl[10] = mk(5'b11111, 4'b0000, 3);
    tbl[11] = mk(5'b11111, 4'b0000, 2);
    tbl[12] = mk(5'b11011, 4'b0000, 1);
    tbl[13] = mk(5'b11100, 4'b0000, 0);
    tbl[14] = mk(5'b11100, 4'b0011, 0);

    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check("reset isolate_o", isolate_o, 0);
    check("reset isolate_ack_o", isolate_ack_o, 0);
    check("reset wr", wr_outstanding_o, 0);
    check("reset rd", rd_outstanding_o, 0);
    check("reset timeout_o", timeout_o, 0);
    tick();
    rst_ni = 1'b1;
    tick();

    // Idle isolate, release, then draining three writes.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].req, tbl[i].awv, tbl[i].awr, 0, 0, tbl[i].bv, tbl[i].br, 0, 0, 0);
      check($sformatf("vec%0d aw_valid_o", i), aw_valid_o, tbl[i].e_awv);
      check($sformatf("vec%0d aw_ready_o", i), aw_ready_o, tbl[i].e_awr);
      check($sformatf("vec%0d isolate_o", i), isolate_o, tbl[i].e_iso);
      check($sformatf("vec%0d isolate_ack_o", i), isolate_ack_o, tbl[i].e_ack);
      check($sformatf("vec%0d wr", i), wr_outstanding_o, tbl[i].e_wr);
      check($sformatf("vec%0d rd", i), rd_outstanding_o, 0);
      tick();
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Pending AW when the request rises is allowed to complete.
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("pend aw_valid_o run", aw_valid_o, 1); tick();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("pend aw_valid_o req", aw_valid_o, 1); tick();
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0); check("pend aw_valid_o drain", aw_valid_o, 1); tick();
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); check("pend aw_ready_o hs", aw_ready_o, 1); tick();
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("pend aw_valid_o blocked", aw_valid_o, 0);
    check("pend wr counted", wr_outstanding_o, 1);
    tick();
    step(1, 0, 0, 0, 0, 1, 1, 0, 0, 0); check("pend ack before B", isolate_ack_o, 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("pend ack after B", isolate_ack_o, 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("pend ack set", isolate_ack_o, 1); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();

    // Abort: request drops mid-drain with two writes outstanding.
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("abort wr", wr_outstanding_o, 2); tick();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("abort gated in drain", aw_valid_o, 0);
    check("abort isolate_o drain", isolate_o, 0);
    tick();
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("abort ungated", aw_valid_o, 1);
    check("abort isolate_o run", isolate_o, 0);
    check("abort wr kept", wr_outstanding_o, 2);
    tick();
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 1, 1, 0, 0, 0); tick();
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("abort wr drained", wr_outstanding_o, 0); tick();

    // Read saturation at MAXO outstanding.
    for (int i = 0; i < MAXO; i++) begin
      step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0); tick();
    end
    step(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    check("sat rd full", rd_outstanding_o, MAXO);
    check("sat ar_valid_o", ar_valid_o, 0);
    check("sat ar_ready_o", ar_ready_o, 0);
    tick();
    step(0, 0, 0, 1, 1, 0, 0, 1, 1, 0); check("sat non-last blocked", ar_valid_o, 0); tick();
    step(0, 0, 0, 1, 1, 0, 0, 1, 1, 1);
    check("sat non-last no dec", rd_outstanding_o, MAXO);
    check("sat last blocked", ar_valid_o, 0);
    tick();
    step(0, 0, 0, 1, 1, 0, 0, 1, 1, 1);
    check("sat rd after last", rd_outstanding_o, MAXO - 1);
    check("sat ar_valid_o reopen", ar_valid_o, 1);
    check("sat ar_ready_o reopen", ar_ready_o, 1);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("sat inc+dec same", rd_outstanding_o, MAXO - 1); tick();
    for (int i = 0; i < MAXO - 1; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1); tick();
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("sat rd drained", rd_outstanding_o, 0); tick();

    // Asynchronous reset in the middle of a drain.
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 1, 1, 0, 0, 0, 0, 0, 0, 0); check("arst pre gated", aw_valid_o, 0);
    #1 rst_ni = 1'b0;
    #1;
    check("arst wr cleared", wr_outstanding_o, 0);
    check("arst ungated", aw_valid_o, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b1;
    tick();

`ifdef AXI_ISOLATE_TIMEOUT_EN
    // A B that never returns must end in a forced isolate.
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0); tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    while (!isolate_o && n < 40) begin
      tick();
      @(negedge clk_i);
      n++;
    end
    check("tmo cycles to isolate", n, TMO + 1);
    check("tmo timeout_o", timeout_o, 1);
    check("tmo wr cleared", wr_outstanding_o, 0);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); check("tmo sticky", timeout_o, 1); tick();
`else
    n = 0;
`endif

    // Randomized run against the model, from a fresh reset.
    rst_ni = 1'b0;
    tick();
    tick();
    rst_ni = 1'b1;
    m_mode = M_RUN; m_wr = 0; m_rd = 0; m_tmr = TMO;
    m_awp = 0; m_arp = 0; m_iso = 0; m_ack = 0; m_tout = 0;
    r_req = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) r_req = !r_req;
      heavy = ((c / 400) % 2) == 1;
      awv = $urandom_range(0, 3) != 0;
      awr = $urandom_range(0, 1) == 1;
      arv = $urandom_range(0, 3) != 0;
      arr = $urandom_range(0, 1) == 1;
      bv  = (m_wr > 0) && ($urandom_range(0, 1) == 1);
      br  = $urandom_range(0, 1) == 1;
      rv  = (m_rd > 0) && (heavy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      rr  = $urandom_range(0, 1) == 1;
      rl  = $urandom_range(0, 1) == 1;
      drive(r_req, awv, awr, arv, arr, bv, br, rv, rr, rl);

      gw = ((m_mode != M_RUN) || (m_wr == MAXO)) && !m_awp;
      gr = ((m_mode != M_RUN) || (m_rd == MAXO)) && !m_arp;
      e_awv = awv && !gw; e_awr = awr && !gw;
      e_arv = arv && !gr; e_arr = arr && !gr;

      @(negedge clk_i);
      check("rnd aw_valid_o", aw_valid_o, e_awv);
      check("rnd aw_ready_o", aw_ready_o, e_awr);
      check("rnd ar_valid_o", ar_valid_o, e_arv);
      check("rnd ar_ready_o", ar_ready_o, e_arr);
      check("rnd isolate_o", isolate_o, m_iso);
      check("rnd isolate_ack_o", isolate_ack_o, m_ack);
      check("rnd wr", wr_outstanding_o, m_wr);
      check("rnd rd", rd_outstanding_o, m_rd);
      check("rnd timeout_o", timeout_o, m_tout);
      @(posedge clk_i);

      drained = (m_wr == 0) && (m_rd == 0) && !m_awp && !m_arp;
      fire = 0;
`ifdef AXI_ISOLATE_TIMEOUT_EN
      if (m_mode == M_DRAIN && r_req && !drained) begin
        m_tmr--;
        fire = (m_tmr == 0);
      end
`endif
      if ((e_awv && awr) && !(bv && br)) m_wr++;
      else if (!(e_awv && awr) && (bv && br) && m_wr > 0) m_wr--;
      if ((e_arv && arr) && !(rv && rr && rl)) m_rd++;
      else if (!(e_arv && arr) && (rv && rr && rl) && m_rd > 0) m_rd--;
      if (e_awv && !awr) m_awp = 1; else if (e_awv && awr) m_awp = 0;
      if (e_arv && !arr) m_arp = 1; else if (e_arv && arr) m_arp = 0;

      case (m_mode)
        M_RUN:   if (r_req) begin m_mode = M_DRAIN; m_tmr = TMO; end
        M_DRAIN: if (!r_req) m_mode = M_RUN;
                 else if (drained || fire) begin m_mode = M_ISO; m_iso = 1; m_ack = 1; end
        M_ISO:   if (!r_req) begin m_mode = M_REL; m_iso = 0; m_ack = 0; end
        default: if (r_req) begin m_mode = M_DRAIN; m_tmr = TMO; end else m_mode = M_RUN;
      endcase
      if (fire) begin
        m_wr = 0; m_rd = 0; m_awp = 0; m_arp = 0; m_tout = 1;
      end
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
